// File: rtl/matrix_loader.sv
// Streams dimension and element beats into two operand matrices for a multiplier.
// Optional C1 == R2 dimension compatibility check: define LOADER_DIM_CHECK_EN.
module matrix_loader #(
  parameter int DATA_W    = 4,
  parameter int ELEM_W    = 32,
  parameter int MAX_ELEMS = 8,
  parameter int DIM_W     = 4,
  localparam int AW       = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic [1:0]        ctrl,
  input  logic              start,
  output logic [DIM_W-1:0]  R1,
  output logic [DIM_W-1:0]  C1,
  output logic [DIM_W-1:0]  R2,
  output logic [DIM_W-1:0]  C2,
  output logic              ready,
  output logic              err,
  input  logic              rd_sel,
  input  logic [AW-1:0]     rd_addr,
  output logic [ELEM_W-1:0] rd_data
);
  localparam int BEATS = ELEM_W / DATA_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = 2 * DIM_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DIMS   = 3'd1;
  localparam logic [2:0] S_LOAD_A = 3'd2;
  localparam logic [2:0] S_LOAD_B = 3'd3;
  localparam logic [2:0] S_READY  = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  logic [2:0]        r_state;
  logic [DIM_W-1:0]  r_r1, r_c1, r_r2, r_c2;
  logic [PW-1:0]     r_na, r_nb;
  logic [PW-1:0]     r_elem;
  logic [BW-1:0]     r_beat;
  logic [1:0]        r_didx;
  logic [ELEM_W-1:0] r_acc;
  logic [ELEM_W-1:0] r_mem_a [MAX_ELEMS];
  logic [ELEM_W-1:0] r_mem_b [MAX_ELEMS];

  logic              w_clr, w_data, w_dimb, w_last_beat, w_last_elem_a, w_last_elem_b;
  logic              w_bad, w_mismatch, w_we_a, w_we_b;
  logic [DIM_W-1:0]  w_dim;
  logic [PW-1:0]     w_prod_a, w_prod_b;
  logic [ELEM_W-1:0] w_elem;

  assign w_clr  = valid_in && (ctrl == 2'd2);
  assign w_data = valid_in && (ctrl == 2'd0);
  assign w_dimb = valid_in && (ctrl == 2'd1);
  assign w_dim  = data_in[DIM_W-1:0];

  // Products at full 2*DIM_W width; the B product uses C2 as it arrives.
  assign w_prod_a = PW'(r_r1) * PW'(r_c1);
  assign w_prod_b = PW'(r_r2) * PW'(w_dim);

`ifdef LOADER_DIM_CHECK_EN
  assign w_mismatch = (r_c1 != r_r2);
`else
  assign w_mismatch = 1'b0;
`endif

  assign w_bad = (r_r1 == '0) || (r_c1 == '0) || (r_r2 == '0) || (w_dim == '0) ||
                 (int'(w_prod_a) > MAX_ELEMS) || (int'(w_prod_b) > MAX_ELEMS) || w_mismatch;

  // Current beat lands in its slot, least significant beat first.
  always_comb begin
    w_elem = r_acc;
    w_elem[r_beat*DATA_W +: DATA_W] = data_in;
  end

  assign w_last_beat   = (r_beat == BW'(BEATS - 1));
  assign w_last_elem_a = (r_elem == r_na - PW'(1));
  assign w_last_elem_b = (r_elem == r_nb - PW'(1));
  assign w_we_a = !RST && (r_state == S_LOAD_A) && w_data && w_last_beat;
  assign w_we_b = !RST && (r_state == S_LOAD_B) && w_data && w_last_beat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_r1    <= '0;
      r_c1    <= '0;
      r_r2    <= '0;
      r_c2    <= '0;
      r_na    <= '0;
      r_nb    <= '0;
      r_elem  <= '0;
      r_beat  <= '0;
      r_didx  <= '0;
      r_acc   <= '0;
    end else if (w_clr) begin
      r_state <= S_IDLE;
      r_elem  <= '0;
      r_beat  <= '0;
      r_didx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dimb) begin
            r_r1    <= w_dim;
            r_didx  <= '0;
            r_state <= S_DIMS;
          end else if (w_data) begin
            r_state <= S_ERROR;
          end
        end
        S_DIMS: begin
          if (w_dimb) begin
            r_didx <= r_didx + 2'd1;
            case (r_didx)
              2'd0:    r_c1 <= w_dim;
              2'd1:    r_r2 <= w_dim;
              default: begin
                r_c2    <= w_dim;
                r_na    <= w_prod_a;
                r_nb    <= w_prod_b;
                r_elem  <= '0;
                r_beat  <= '0;
                r_state <= w_bad ? S_ERROR : S_LOAD_A;
              end
            endcase
          end else if (w_data) begin
            r_state <= S_ERROR;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (w_dimb) begin
            r_state <= S_ERROR;
          end else if (w_data) begin
            if (w_last_beat) begin
              r_beat <= '0;
              if ((r_state == S_LOAD_A) ? w_last_elem_a : w_last_elem_b) begin
                r_elem  <= '0;
                r_state <= (r_state == S_LOAD_A) ? S_LOAD_B : S_READY;
              end else begin
                r_elem <= r_elem + PW'(1);
              end
            end else begin
              r_beat <= r_beat + BW'(1);
              r_acc  <= w_elem;
            end
          end
        end
        S_READY: if (start) r_state <= S_IDLE;
        S_ERROR: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Element storage is deliberately never reset.
  always_ff @(posedge CLK) begin
    if (w_we_a) r_mem_a[AW'(r_elem)] <= w_elem;
    if (w_we_b) r_mem_b[AW'(r_elem)] <= w_elem;
  end

  assign rd_data = rd_sel ? r_mem_b[rd_addr] : r_mem_a[rd_addr];
  assign R1      = r_r1;
  assign C1      = r_c1;
  assign R2      = r_r2;
  assign C2      = r_c2;
  assign ready   = (r_state == S_READY);
  assign err     = (r_state == S_ERROR);
endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader with default parameters.
module tb_matrix_loader;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  data_in = '0;
  logic        valid_in = 1'b0;
  logic [1:0]  ctrl = '0;
  logic        start = 1'b0;
  logic [3:0]  R1, C1, R2, C2;
  logic        ready, err;
  logic        rd_sel = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data;

  int n_cmp = 0;
  int n_mis = 0;

  matrix_loader dut (
    .CLK(CLK), .RST(RST), .data_in(data_in), .valid_in(valid_in), .ctrl(ctrl),
    .start(start), .R1(R1), .C1(C1), .R2(R2), .C2(C2), .ready(ready), .err(err),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [3:0] d);
    valid_in = 1'b1; ctrl = c; data_in = d;
    @(posedge CLK); #1;
    valid_in = 1'b0; ctrl = 2'd0; data_in = '0;
  endtask

  task automatic send_elem(input logic [31:0] v);
    for (int i = 0; i < 8; i++) send(2'd0, v[i*4 +: 4]);
  endtask

  task automatic send_dims(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
    send(2'd1, a); send(2'd1, b); send(2'd1, c); send(2'd1, d);
  endtask

  task automatic rd(input logic s, input logic [2:0] a, input string tag, input logic [31:0] exp);
    rd_sel = s; rd_addr = a; #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    check("rst_ready", ready, 0);
    check("rst_err", err, 0);
    check("rst_dims", {R1, C1, R2, C2}, 0);

    // Full 2x2 / 2x2 load
    send_dims(2, 2, 2, 2);
    check("dims_2222", {R1, C1, R2, C2}, 16'h2222);
    check("dims_ok_err", err, 0);
    for (int e = 1; e <= 4; e++) send_elem(e);
    for (int e = 5; e <= 7; e++) send_elem(e);
    for (int i = 0; i < 7; i++) send(2'd0, (i == 0) ? 4'd8 : 4'd0);
    check("ready_before_last", ready, 0);
    send(2'd0, 4'd0);
    check("ready_after_last", ready, 1);
    rd(1, 3, "rd_b3", 32'd8);
    rd(1, 0, "rd_b0", 32'd5);
    rd(0, 2, "rd_a2", 32'd3);

    // Dimension and data beats ignored in READY, start ignored elsewhere is tested below
    send(2'd1, 4'd5);
    check("ready_dim_ignored", {R1, ready}, {4'd2, 1'b1});
    send(2'd3, 4'd7);
    check("ready_ctrl3_ignored", ready, 1);

    // start alone
    start = 1'b1; @(posedge CLK); #1; start = 1'b0;
    check("start_ready0", {ready, err}, 2'b00);
    rd(1, 3, "start_keep_b3", 32'd8);
    check("start_keep_dims", {R1, C1, R2, C2}, 16'h2222);
    send(2'd0, 4'd1);
    check("idle_data_err", err, 1);
    send(2'd1, 4'd1);
    check("error_dim_ignored", {err, R1}, {1'b1, 4'd2});
    send(2'd2, 4'd0);
    check("clear_err", err, 0);

    // start + clear together in READY
    send_dims(1, 1, 1, 1);
    send_elem(32'hA5A5A5A5);
    send_elem(32'h12345678);
    check("one_ready", ready, 1);
    rd(0, 0, "one_a0", 32'hA5A5A5A5);
    rd(1, 0, "one_b0", 32'h12345678);
    valid_in = 1'b1; ctrl = 2'd2; start = 1'b1;
    @(posedge CLK); #1;
    valid_in = 1'b0; ctrl = 2'd0; start = 1'b0;
    check("clr_start", {ready, err}, 2'b00);
    send(2'd0, 4'd0);
    check("clr_start_idle", err, 1);
    send(2'd2, 4'd0);

    // Oversize
    send_dims(3, 3, 3, 3);
    check("over_err", err, 1);
    start = 1'b1; send(2'd0, 4'd1); start = 1'b0;
    check("over_hold", err, 1);
    send(2'd2, 4'd0);
    check("over_clear", {err, ready, R1}, {1'b0, 1'b0, 4'd3});

    // Zero dimension
    send_dims(1, 1, 1, 0);
    check("zero_err", err, 1);
    send(2'd2, 4'd0);

    // Exact capacity boundary 4x2 / 2x4
    send_dims(4, 2, 2, 4);
    check("max_ok", err, 0);
    send(2'd2, 4'd0);

    // Incompatible inner dimensions
    send_dims(2, 3, 2, 2);
`ifdef LOADER_DIM_CHECK_EN
    check("mismatch_err", err, 1);
    send(2'd2, 4'd0);
`else
    check("mismatch_no_err", err, 0);
    for (int e = 0; e < 6; e++) send_elem(32'h100 + e);
    for (int e = 0; e < 3; e++) send_elem(32'h200 + e);
    check("mm_not_ready", ready, 0);
    send_elem(32'h203);
    check("mm_ready", ready, 1);
    rd(0, 5, "mm_a5", 32'h105);
    rd(1, 3, "mm_b3", 32'h203);
    send(2'd2, 4'd0);
`endif

    // Dimension beat in LOAD_A
    send_dims(2, 2, 2, 2);
    for (int e = 0; e < 3; e++) send_elem(32'h30 + e);
    check("loada_no_err", err, 0);
    send(2'd1, 4'd1);
    check("loada_dim_err", err, 1);
    send(2'd2, 4'd0);

    // Reset mid LOAD_B, then a fresh load with ctrl=3 beats interleaved
    send_dims(2, 2, 2, 2);
    for (int e = 0; e < 6; e++) send_elem(32'h40 + e);
    RST = 1'b1; @(posedge CLK); #1; RST = 1'b0;
    check("rst_mid_state", {ready, err}, 2'b00);
    check("rst_mid_dims", {R1, C1, R2, C2}, 0);
    send(2'd3, 4'd0);
    send_dims(2, 2, 2, 2);
    send(2'd0, 4'hF);
    send(2'd3, 4'h9);
    for (int i = 1; i < 8; i++) send(2'd0, 4'(i));
    for (int e = 1; e < 8; e++) send_elem(32'hC0DE0000 + e);
    check("fresh_ready", ready, 1);
    rd(0, 0, "fresh_a0", 32'h7654321F);
    rd(1, 3, "fresh_b3", 32'hC0DE0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
